priority_encoder_8to3: RTL and testbench



---
 rtl/prio_enc_pkg.sv | 10 +
 rtl/prio_enc_core.sv | 35 +++
 rtl/priority_encoder_8to3.sv | 59 +++++
 tb/tb_priority_encoder_8to3.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared sizing constants and types for the 8-to-3 priority encoder.
package prio_enc_pkg;

    localparam int PRIO_ENC_WIDTH = 8;
    localparam int PRIO_ENC_OUT_W = 3;

    typedef logic [PRIO_ENC_WIDTH-1:0] req_vec_t;
    typedef logic [PRIO_ENC_OUT_W-1:0] idx_t;

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority scan: request vector in, winning index and any-request flag out.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int WIDTH     = PRIO_ENC_WIDTH,
    parameter bit LSB_FIRST = 1'b0,
    localparam int OUT_W    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] idx,
    output logic             vld
);

    // The last hit in scan order wins, so the scan runs toward the winning end.
    // An empty vector leaves idx at its zero default.
    always_comb begin
        idx = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in[i]) begin
                    idx = OUT_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in[i]) begin
                    idx = OUT_W'(i);
                end
            end
        end
    end

    assign vld = |in;

endmodule

// File: rtl/priority_encoder_8to3.sv
// Registered priority encoder: one-cycle latency, a new request vector every cycle.
// Optional registered one-hot output when PRIO_ONEHOT_OUT_EN is defined.
module priority_encoder_8to3
    import prio_enc_pkg::*;
#(
    parameter int WIDTH     = PRIO_ENC_WIDTH,
    parameter bit LSB_FIRST = 1'b0,
    localparam int OUT_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             valid
`ifdef PRIO_ONEHOT_OUT_EN
    ,
    output logic [WIDTH-1:0] onehot
`endif
);

    // valid qualifies out in the same cycle; there is no backpressure, and out
    // reads 0 whenever valid is 0.
    logic [OUT_W-1:0] idx;
    logic             vld;

    prio_enc_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .in  (in),
        .idx (idx),
        .vld (vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= idx;
            valid <= vld;
        end
    end

`ifdef PRIO_ONEHOT_OUT_EN
    logic [WIDTH-1:0] onehot_d;

    assign onehot_d = vld ? (WIDTH'(1) << idx) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            onehot <= '0;
        end else begin
            onehot <= onehot_d;
        end
    end
`endif

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Bench for priority_encoder_8to3: MSB-first and LSB-first instances against a reference model.
module tb_priority_encoder_8to3;
    import prio_enc_pkg::*;

    // Expected entry: {valid, msb-first index, lsb-first index}
    localparam int EXP_W = 1 + 2 * PRIO_ENC_OUT_W;

    logic     clk;
    logic     rst_n;
    req_vec_t in;
    idx_t     out_hi;
    idx_t     out_lo;
    logic     valid_hi;
    logic     valid_lo;
`ifdef PRIO_ONEHOT_OUT_EN
    req_vec_t onehot_hi;
    req_vec_t onehot_lo;
`endif

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    priority_encoder_8to3 #(.LSB_FIRST(1'b0)) dut_hi (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .out    (out_hi),
        .valid  (valid_hi)
`ifdef PRIO_ONEHOT_OUT_EN
        ,
        .onehot (onehot_hi)
`endif
    );

    priority_encoder_8to3 #(.LSB_FIRST(1'b1)) dut_lo (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .out    (out_lo),
        .valid  (valid_lo)
`ifdef PRIO_ONEHOT_OUT_EN
        ,
        .onehot (onehot_lo)
`endif
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 1'b0;
        in    = 8'hFF;
    end

    // Reference: highest set bit is floor(log2(v)); lowest set bit is isolated by v & -v.
    function automatic int model_hi(input int v);
        if (v == 0) return 0;
        return $clog2(v + 1) - 1;
    endfunction

    function automatic int model_lo(input int v);
        if (v == 0) return 0;
        return $clog2(v & (-v));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare the registered outputs with the oldest expectation.
    task automatic check_outputs();
        logic [EXP_W-1:0] e;
        logic             e_vld;
        idx_t             e_hi;
        idx_t             e_lo;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        {e_vld, e_hi, e_lo} = e;
        check("valid_hi", 32'(valid_hi), 32'(e_vld));
        check("out_hi",   32'(out_hi),   32'(e_hi));
        check("valid_lo", 32'(valid_lo), 32'(e_vld));
        check("out_lo",   32'(out_lo),   32'(e_lo));
`ifdef PRIO_ONEHOT_OUT_EN
        check("onehot_hi", 32'(onehot_hi), e_vld ? (32'd1 << e_hi) : 32'd0);
        check("onehot_lo", 32'(onehot_lo), e_vld ? (32'd1 << e_lo) : 32'd0);
`endif
    endtask

    // Driver: on the falling edge check last cycle's result, then apply the next vector.
    task automatic step(input req_vec_t v, input logic r);
        int vi;
        @(negedge clk);
        check_outputs();
        in    = v;
        rst_n = r;
        vi    = int'(v);
        if (!r) exp_q.push_back('0);
        else    exp_q.push_back({(v != 0), idx_t'(model_hi(vi)), idx_t'(model_lo(vi))});
    endtask

    initial begin
        req_vec_t v;

        // Reset held with all requests high, then release
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b1);

        // Exhaustive sweep
        for (int i = 0; i < 256; i++) step(req_vec_t'(i), 1'b1);

        // Walking one
        for (int k = 0; k < PRIO_ENC_WIDTH; k++) step(req_vec_t'(1 << k), 1'b1);

        // Priority overlap
        step(8'b0010_1101, 1'b1);
        step(8'b1000_0001, 1'b1);
        step(8'b0010_1100, 1'b1);

        // Zero and back-to-back
        step(8'h00, 1'b1);
        step(8'h40, 1'b1);
        step(8'h00, 1'b1);

        // Mid-run reset while streaming
        step(8'h10, 1'b1);
        step(8'h10, 1'b1);
        step(8'h10, 1'b0);
        step(8'h10, 1'b1);
        step(8'h10, 1'b1);

        // Random vectors with occasional reset pulses
        for (int n = 0; n < 300; n++) begin
            v = req_vec_t'($urandom_range(0, 255));
            step(v, ($urandom_range(0, 19) != 0));
        end

        // Drain the final expectation
        @(negedge clk);
        check_outputs();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
